// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_pkg
//  Description : Shared opcode map, encoder states and instruction word
//                field positions for the accumulator CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'd0,
        OP_LOAD     = 4'd1,
        OP_STOREMEM = 4'd2,
        OP_STORERF  = 4'd3,
        OP_JUMP     = 4'd4,
        OP_ADD      = 4'd5,
        OP_SUB      = 4'd6,
        OP_AND      = 4'd7,
        OP_OR       = 4'd8,
        OP_XOR      = 4'd9,
        OP_NOT      = 4'd10,
        OP_SHL      = 4'd11,
        OP_SHR      = 4'd12,
        OP_INC      = 4'd13,
        OP_DEC      = 4'd14,
        OP_CMP      = 4'd15
    } cpu_instructions;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } encoder_state_t;

    localparam int INSTR_WIDTH   = 16;
    localparam int OPND_WIDTH    = 10;
    localparam int PROGRAM_DEPTH = 32;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_MSB   = 3;
    localparam int SEL_LSB      = 4;
    localparam int SEL_MSB      = 5;
    localparam int RF_LSB       = 6;
    localparam int RF_MSB       = 7;
    localparam int MEM_LSB      = 6;
    localparam int MEM_MSB      = 15;
    localparam int IMM_LD_LSB   = 8;
    localparam int IMM_LD_MSB   = 15;
    localparam int IMM_ALU_LSB  = 7;
    localparam int IMM_ALU_MSB  = 14;
    localparam int JUMP_LSB     = 4;
    localparam int JUMP_MSB     = 8;
    localparam int STMEM_LSB    = 4;
    localparam int STMEM_MSB    = 13;
    localparam int STRF_LSB     = 4;
    localparam int STRF_MSB     = 5;

endpackage
`default_nettype wire

// File: rtl/instruction_packer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_packer
//  Description : Combinational map from (opcode, selector, operand) to the
//                16-bit decoder word, with a legality flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_packer
    import id_pkg::*;
(
    input  logic [3:0]             opcode,
    input  logic [1:0]             selector,
    input  logic [OPND_WIDTH-1:0]  operand,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   legal
);

    // Range checks on the raw operand, expressed as "upper bits are zero"
    logic w_fits_rf;
    logic w_fits_imm;
    logic w_fits_jump;

    assign w_fits_rf   = (operand[OPND_WIDTH-1:2] == '0);
    assign w_fits_imm  = (operand[OPND_WIDTH-1:8] == '0);
    assign w_fits_jump = (operand[OPND_WIDTH-1:5] == '0);

    always_comb begin
        word                        = '0;
        legal                       = 1'b1;
        word[OPCODE_MSB:OPCODE_LSB] = opcode;
        case (cpu_instructions'(opcode))
            OP_NOP: begin
                legal = (operand == '0);
            end
            OP_STOREMEM: begin
                word[STMEM_MSB:STMEM_LSB] = operand;
            end
            OP_STORERF: begin
                word[STRF_MSB:STRF_LSB] = operand[1:0];
                legal                   = w_fits_rf;
            end
            OP_JUMP: begin
                word[JUMP_MSB:JUMP_LSB] = operand[4:0];
                legal                   = w_fits_jump;
            end
            default: begin
                // LOAD and every ALU code share the selector-based formats
                word[SEL_MSB:SEL_LSB] = selector;
                case (selector)
                    SEL_MEM: begin
                        word[MEM_MSB:MEM_LSB] = operand;
                    end
                    SEL_IMM: begin
                        legal = w_fits_imm;
                        if (opcode == OP_LOAD) begin
                            word[IMM_LD_MSB:IMM_LD_LSB] = operand[7:0];
                        end else begin
                            word[IMM_ALU_MSB:IMM_ALU_LSB] = operand[7:0];
                        end
                    end
                    default: begin
                        word[RF_MSB:RF_LSB] = operand[1:0];
                        legal               = w_fits_rf;
                    end
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/program_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : program_encoder
//  Description : Accepts symbolic instructions over valid/ready, packs them
//                and writes them to consecutive program-memory addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_encoder
    import id_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int OPERAND_WIDTH     = 10,
    parameter int PC_VALUE_WIDTH    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_opcode,
    input  logic [1:0]                   in_selector,
    input  logic [OPERAND_WIDTH-1:0]     in_operand,
    output logic                         wr_en,
    output logic [PC_VALUE_WIDTH-1:0]    wr_addr,
    output logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         err,
    output logic                         full,
    output logic [PC_VALUE_WIDTH:0]      count
);

    localparam logic [PC_VALUE_WIDTH:0] c_last_count = {1'b0, {PC_VALUE_WIDTH{1'b1}}};

    encoder_state_t                 r_state;
    encoder_state_t                 w_next_state;
    logic [PC_VALUE_WIDTH-1:0]      r_ptr;
    logic [PC_VALUE_WIDTH:0]        r_count;
    logic [INSTRUCTION_WIDTH-1:0]   r_word;
    logic                           r_err;

    logic [INSTRUCTION_WIDTH-1:0]   w_word;
    logic                           w_legal;
    logic                           w_xfer;

    instruction_packer u_packer (
        .opcode   (in_opcode),
        .selector (in_selector),
        .operand  (in_operand),
        .word     (w_word),
        .legal    (w_legal)
    );

    assign w_xfer = in_valid && (r_state == IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_xfer && w_legal) w_next_state = WRITE;
            WRITE:   w_next_state = (r_count == c_last_count) ? FULL : IDLE;
            FULL:    w_next_state = FULL;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_xfer && !w_legal;
            if (w_xfer && w_legal) begin
                r_word <= w_word;
            end
            // The pointer parks on the last address once the memory fills
            if (r_state == WRITE) begin
                r_count <= r_count + 1'b1;
                if (r_count != c_last_count) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    assign in_ready = (r_state == IDLE);
    assign wr_en    = (r_state == WRITE);
    assign full     = (r_state == FULL);
    assign wr_addr  = r_ptr;
    assign wr_data  = r_word;
    assign err      = r_err;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_program_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_encoder
//  Description : Scoreboard bench for program_encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_encoder;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = '0;
    logic [1:0]  in_selector = '0;
    logic [9:0]  in_operand = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        err;
    logic        full;
    logic [5:0]  count;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_w;

    program_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_selector (in_selector),
        .in_operand  (in_operand),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .err         (err),
        .full        (full),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [3:0] op, input logic [1:0] sel,
                                          input logic [9:0] opnd, output logic ok);
        logic [15:0] w;
        ok = 1'b1;
        w  = {12'd0, op};
        if (op == 4'd0) begin
            ok = (opnd == 10'd0);
        end else if (op == 4'd2) begin
            w = {2'b00, opnd, op};
        end else if (op == 4'd3) begin
            w = {10'd0, opnd[1:0], op}; ok = (opnd < 10'd4);
        end else if (op == 4'd4) begin
            w = {7'd0, opnd[4:0], op}; ok = (opnd < 10'd32);
        end else if (sel == 2'b01) begin
            w = {opnd, sel, op};
        end else if (sel == 2'b10) begin
            ok = (opnd < 10'd256);
            if (op == 4'd1) w = {opnd[7:0], 2'b00, sel, op};
            else            w = {1'b0, opnd[7:0], 1'b0, sel, op};
        end else begin
            w = {8'd0, opnd[1:0], sel, op}; ok = (opnd < 10'd4);
        end
        return w;
    endfunction

    // Drives one instruction and queues its expected word if it is legal
    task automatic drive(input logic [3:0] op, input logic [1:0] sel, input logic [9:0] opnd);
        logic ok;
        logic [15:0] w;
        w = model(op, sel, opnd, ok);
        in_valid = 1'b1; in_opcode = op; in_selector = sel; in_operand = opnd;
        if (ok) sb_q.push_back(w);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        total++;
        if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        total++;
        if (wr_addr !== 5'd0 || wr_data !== 16'd0) begin bad++; $display("FAIL reset_wr: addr %0d data %h want 0/0", wr_addr, wr_data); end
        total++;
        if (err !== 1'b0 || full !== 1'b0 || count !== 6'd0) begin bad++; $display("FAIL reset_status: err %b full %b count %0d want 0", err, full, count); end
        total++;
    endtask

    task automatic test_load_imm();
        do_reset();
        drive(OP_LOAD, 2'b10, 10'h05A);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_w = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_addr !== 5'd0) begin bad++; $display("FAIL load_write: wr_en %b addr %0d want 1/0", wr_en, wr_addr); end
        total++;
        if (wr_data !== exp_w || wr_data[15:8] !== 8'h5A) begin bad++; $display("FAIL load_data: got %h want %h", wr_data, exp_w); end
        total++;
        @(posedge clk); #1;
        if (count !== 6'd1 || wr_en !== 1'b0) begin bad++; $display("FAIL load_count: count %0d wr_en %b want 1/0", count, wr_en); end
        total++;
    endtask

    task automatic test_storemem_jump();
        do_reset();
        drive(OP_STOREMEM, 2'b00, 10'h3FF);
        @(posedge clk); #1;
        drive(OP_JUMP, 2'b00, 10'd17);
        exp_w = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== exp_w || in_ready !== 1'b0) begin
            bad++; $display("FAIL storemem: en %b addr %0d data %h ready %b want 1/0/%h/0", wr_en, wr_addr, wr_data, in_ready, exp_w);
        end
        total++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_w = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== exp_w || wr_data[8:4] !== 5'b10001 || in_ready !== 1'b0) begin
            bad++; $display("FAIL jump: en %b addr %0d data %h ready %b want 1/1/%h/0", wr_en, wr_addr, wr_data, in_ready, exp_w);
        end
        total++;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_imm();
        do_reset();
        drive(OP_ADD, 2'b10, 10'h0FF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_w = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_data !== exp_w || wr_data[14:7] !== 8'hFF || wr_data[15] !== 1'b0) begin
            bad++; $display("FAIL alu_imm: en %b data %h want 1/%h", wr_en, wr_data, exp_w);
        end
        total++;
        @(posedge clk); #1;
    endtask

    task automatic test_reject();
        logic [3:0] ops [5]  = '{OP_STORERF, OP_NOP, OP_LOAD, OP_ADD, OP_JUMP};
        logic [1:0] sels [5] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
        logic [9:0] opns [5] = '{10'd4, 10'd1, 10'd256, 10'd4, 10'd32};
        do_reset();
        drive(OP_LOAD, 2'b00, 10'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_w = sb_q.pop_front();
        @(posedge clk); #1;
        // Back-to-back illegal instructions with in_valid held high
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], sels[i], opns[i]);
            @(posedge clk); #1;
            if (err !== 1'b1 || wr_en !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL reject_%0d: err %b wr_en %b ready %b want 1/0/1", i, err, wr_en, in_ready);
            end
            total++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (err !== 1'b0 || count !== 6'd1 || sb_q.size() != 0) begin
            bad++; $display("FAIL reject_after: err %b count %0d queued %0d want 0/1/0", err, count, sb_q.size());
        end
        total++;
        drive(OP_STORERF, 2'b00, 10'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_w = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== exp_w) begin
            bad++; $display("FAIL reject_next: en %b addr %0d data %h want 1/1/%h", wr_en, wr_addr, wr_data, exp_w);
        end
        total++;
        @(posedge clk); #1;
    endtask

    task automatic legal_random(output logic [3:0] op, output logic [1:0] sel, output logic [9:0] opnd);
        op  = 4'($urandom_range(0, 15));
        sel = 2'($urandom_range(0, 3));
        case (op)
            4'd0:    opnd = 10'd0;
            4'd2:    opnd = 10'($urandom_range(0, 1023));
            4'd3:    opnd = 10'($urandom_range(0, 3));
            4'd4:    opnd = 10'($urandom_range(0, 31));
            default: opnd = (sel == 2'b01) ? 10'($urandom_range(0, 1023)) :
                            (sel == 2'b10) ? 10'($urandom_range(0, 255)) : 10'($urandom_range(0, 3));
        endcase
    endtask

    task automatic test_fill();
        logic [3:0] op;
        logic [1:0] sel;
        logic [9:0] opnd;
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            legal_random(op, sel, opnd);
            drive(op, sel, opnd);
            @(posedge clk); #1;
            exp_w = sb_q.pop_front();
            if (wr_en !== 1'b1 || wr_addr !== 5'(i) || wr_data !== exp_w || in_ready !== 1'b0) begin
                errs++; $display("FAIL fill_%0d: en %b addr %0d data %h want 1/%0d/%h", i, wr_en, wr_addr, wr_data, i, exp_w);
            end
            @(posedge clk); #1;
        end
        if (errs != 0) bad++;
        total++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 6'd32 || wr_addr !== 5'd31 || wr_en !== 1'b0) begin
            bad++; $display("FAIL fill_full: full %b ready %b count %0d addr %0d en %b want 1/0/32/31/0", full, in_ready, count, wr_addr, wr_en);
        end
        total++;
        errs = 0;
        drive(OP_NOP, 2'b00, 10'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wr_en !== 1'b0 || full !== 1'b1 || count !== 6'd32) errs++;
        end
        in_valid = 1'b0;
        if (errs != 0) begin bad++; $display("FAIL fill_ignore: %0d bad cycles want 0", errs); end
        total++;
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(OP_STOREMEM, 2'b00, 10'(i * 37));
            @(posedge clk); #1;
            in_valid = 1'b0;
            exp_w = sb_q.pop_front();
            if (i == 7) begin
                if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== exp_w) begin
                    bad++; $display("FAIL clear_write7: en %b addr %0d data %h want 1/7/%h", wr_en, wr_addr, wr_data, exp_w);
                end
                total++;
                clear = 1'b1;
            end
            @(posedge clk); #1;
        end
        clear = 1'b0;
        if (count !== 6'd0 || in_ready !== 1'b1 || wr_addr !== 5'd0 || wr_en !== 1'b0) begin
            bad++; $display("FAIL clear_state: count %0d ready %b addr %0d en %b want 0/1/0/0", count, in_ready, wr_addr, wr_en);
        end
        total++;
        drive(OP_JUMP, 2'b00, 10'd9);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_w = sb_q.pop_front();
        if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== exp_w) begin
            bad++; $display("FAIL clear_next: en %b addr %0d data %h want 1/0/%h", wr_en, wr_addr, wr_data, exp_w);
        end
        total++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_imm();
        test_storemem_jump();
        test_alu_imm();
        test_reject();
        test_fill();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_encoder.md
# program_encoder

Sequential instruction encoder and program-memory writer for the accumulator CPU. Accepts symbolic instructions (opcode, operand selector, operand value) over a valid/ready handshake. Packs each one into the 16-bit word format that `instruction_decoder` consumes, and writes it to consecutive program-memory addresses starting at 0. It sits between the test/boot loader and the instruction memory and is the writer counterpart of the decoder.

## Interface
- `INSTRUCTION_WIDTH`, 16, encoded word width
- `OPERAND_WIDTH`, 10, width of the raw operand input
- `PC_VALUE_WIDTH`, 5, program address width; depth is 2^PC_VALUE_WIDTH = 32 words
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `clear` in 1: synchronous restart of the program; same effect as `rst`.
- `in_valid` in 1: input instruction present.
- `in_ready` out 1: encoder can accept an instruction.
- `in_opcode` in 4: `cpu_instructions` code.
- `in_selector` in 2: operand source; 00 = RF, 01 = MEM, 10 = IMM, 11 = RF.
- `in_operand` in 10: RF address, MEM address, immediate, or jump target.
- `wr_en` out 1: program-memory write strobe.
- `wr_addr` out 5: write address.
- `wr_data` out 16: encoded word.
- `err` out 1: one-cycle pulse when an instruction is rejected.
- `full` out 1: all 32 words have been written.
- `count` out 6: number of words written, 0..32.

## Operation
- The FSM has three states: IDLE, WRITE and FULL.
- IDLE:
  - `in_ready` = 1.
  - A transfer occurs when `in_valid & in_ready` is high at a rising edge.
  - A legal transfer latches the encoded word and moves to WRITE.
  - An illegal transfer pulses `err` next cycle and stays in IDLE. No write occurs and the address does not advance.
- WRITE:
  - `in_ready` = 0, `wr_en` = 1 for exactly one cycle.
  - `wr_addr` = current pointer, `wr_data` = the latched word.
  - On exit the pointer and `count` increment.
  - Next state is FULL if `count` becomes 32, otherwise IDLE.
- FULL: `in_ready` = 0 and `full` = 1 until `rst` or `clear`.
- Encoding, with all unlisted bits 0 and bits [3:0] = opcode:
  - STOREMEM: [13:4] = operand.
  - STORERF: [5:4] = operand[1:0].
  - JUMP: [8:4] = operand[4:0].
  - NOP: opcode only.
  - LOAD and ALU codes: [5:4] = selector.
    - Selector 00/11: [7:6] = RF address.
    - Selector 01: [15:6] = MEM address.
    - LOAD with selector 10: [15:8] = imm[7:0].
    - ALU with selector 10: [14:7] = imm[7:0], bits 15 and 6 = 0.
- Illegal instructions, which are rejected:
  - An RF operand > 3.
  - An immediate > 255.
  - A JUMP target > 31.
  - A STORERF operand > 3.
  - NOP with a nonzero operand.

## Timing
- Reset values: FSM = IDLE, `in_ready` = 1, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `err` = 0, `full` = 0, `count` = 0.
- Latency: a transfer at edge N gives `wr_en` high during cycle N+1. Peak throughput is one word per 2 cycles.
- `in_ready` is a registered state decode and never depends combinationally on `in_valid`.
- The input fields only need to be stable in the transfer cycle. The word is registered at acceptance.
- `err` is high for exactly the cycle after a rejected transfer. Back-to-back rejections give back-to-back pulses.
- `rst` or `clear` in any state, including during WRITE, returns all registers to reset values at that edge. A WRITE cycle that coincides with the reset edge is still driven for that cycle, but the pointer does not advance.
- Pointer wrap: none. After word 31 the block enters FULL, and `wr_addr` holds 31 with `wr_en` = 0.
- If `rst` and `clear` are both high, the result is the same as a single reset.

## Structure
- Extend `id_pkg` with:
  - `encoder_state_t` (IDLE, WRITE, FULL).
  - Field-position constants for each format (opcode LSB/MSB, selector, RF, MEM, IMM-LOAD, IMM-ALU, JUMP fields).
  - A `PROGRAM_DEPTH` constant.
- `cpu_instructions` from `id_pkg` is the single source of opcode values.
- One combinational sub-module, `instruction_packer`, maps opcode, selector and operand to a word plus a `legal` flag. The FSM, pointer and handshake stay in `program_encoder`.

## Test plan
- Reset, then LOAD, selector 10, operand 0x5A → `wr_en` in cycle N+1, `wr_addr` = 0, `wr_data[15:8]` = 0x5A, `wr_data[5:4]` = 10, `wr_data[3:0]` = LOAD code; `count` = 1.
- STOREMEM, operand 0x3FF, then JUMP, operand 17 → word 0 has [13:4] = 0x3FF; word 1 at address 1 has [8:4] = 10001; `in_ready` is low in each WRITE cycle.
- ALU opcode, selector 10, operand 0xFF → [14:7] = 0xFF and bit 15 = 0. Decoding the word must give IMM_value 0xFF.
- STORERF, operand 4 → `err` pulses for one cycle, no `wr_en`, `count` is unchanged. The next legal instruction is written to the same address.
- 32 legal instructions with `in_valid` held high → 32 writes to addresses 0..31, then `full` = 1 and `in_ready` = 0. A 33rd `in_valid` is ignored.
- `clear` asserted during a WRITE at address 7 → the next edge gives `count` = 0 and state IDLE, and the next accepted instruction is written to address 0.
